// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU: grant, execute, respond.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [96:0] req0_cmd,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [96:0] req1_cmd,
    output logic        req1_ready,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_branch,
    output logic [5:0]  alu_opcode,
    output logic [31:0] alu_rs_content,
    output logic [31:0] alu_rt_content,
    output logic [4:0]  alu_shamt,
    output logic [5:0]  alu_ALU_control,
    output logic [15:0] alu_immediate,
    input  logic [31:0] alu_result,
    input  logic        alu_sig_branch,
    output logic        busy,
    output logic [15:0] ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [96:0] r_cmd;
    logic        r_rspId;
    logic [31:0] r_rspResult;
    logic        r_rspBranch;
    logic        r_rspValid;
    logic        r_busy;
    logic [15:0] r_opsDone;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_idle;

    assign w_idle = (r_state == IDLE);

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        w_grant0 = w_idle && req0_valid;
        w_grant1 = w_idle && req1_valid && !req0_valid;
    end
`else
    // r_lastGrant resets to 1 so requester 0 wins the first tie.
    logic r_lastGrant;

    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (w_idle) begin
            if (req0_valid && req1_valid) begin
                w_grant0 = r_lastGrant;
                w_grant1 = !r_lastGrant;
            end else begin
                w_grant0 = req0_valid;
                w_grant1 = req1_valid;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lastGrant <= 1'b1;
        end else if (w_grant0) begin
            r_lastGrant <= 1'b0;
        end else if (w_grant1) begin
            r_lastGrant <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cmd       <= '0;
            r_rspId     <= 1'b0;
            r_rspResult <= '0;
            r_rspBranch <= 1'b0;
            r_rspValid  <= 1'b0;
            r_busy      <= 1'b0;
            r_opsDone   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_cmd   <= w_grant1 ? req1_cmd : req0_cmd;
                        r_rspId <= w_grant1;
                        r_busy  <= 1'b1;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_rspResult <= alu_result;
                    r_rspBranch <= alu_sig_branch;
                    r_rspValid  <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    r_rspValid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_opsDone  <= r_opsDone + 16'd1;
                    r_state    <= IDLE;
                end
                default: begin
                    r_rspValid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    // The ALU only ever sees the latched command, so requester changes mid-op are invisible.
    assign alu_opcode      = r_cmd[96:91];
    assign alu_rs_content  = r_cmd[90:59];
    assign alu_rt_content  = r_cmd[58:27];
    assign alu_shamt       = r_cmd[26:22];
    assign alu_ALU_control = r_cmd[21:16];
    assign alu_immediate   = r_cmd[15:0];

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign rsp_valid  = r_rspValid;
    assign rsp_id     = r_rspId;
    assign rsp_result = r_rspResult;
    assign rsp_branch = r_rspBranch;
    assign busy       = r_busy;
    assign ops_done   = r_opsDone;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed and random ops against a transaction-level model.
// Honours ALU_ARB_FIXED_PRIO_EN for the expected arbitration policy.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [96:0] req0_cmd, req1_cmd;
    logic        req0_ready, req1_ready;
    logic        rsp_valid, rsp_id, rsp_branch;
    logic [31:0] rsp_result;
    logic [5:0]  alu_opcode, alu_ALU_control;
    logic [31:0] alu_rs_content, alu_rt_content, alu_result;
    logic [4:0]  alu_shamt;
    logic [15:0] alu_immediate, ops_done;
    logic        alu_sig_branch, busy;

    int          total = 0;
    int          bad = 0;
    int          lastWinner = 1;
    int          expOps = 0;
    logic [31:0] expResult = '0;
    logic        expBranch = 1'b0;
    logic        expId = 1'b0;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_branch(rsp_branch),
        .alu_opcode(alu_opcode), .alu_rs_content(alu_rs_content), .alu_rt_content(alu_rt_content),
        .alu_shamt(alu_shamt), .alu_ALU_control(alu_ALU_control), .alu_immediate(alu_immediate),
        .alu_result(alu_result), .alu_sig_branch(alu_sig_branch),
        .busy(busy), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    function automatic logic [96:0] makeCmd(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                            input logic [4:0] sh, input logic [5:0] ctl, input logic [15:0] imm);
        return {op, rs, rt, sh, ctl, imm};
    endfunction

    // Behaviour of the shared ALU: returns {branch, result}.
    function automatic logic [32:0] aluFunc(input logic [96:0] c);
        logic [31:0] rs, rt, r;
        logic [4:0]  sh;
        logic [15:0] imm;
        rs  = c[90:59];
        rt  = c[58:27];
        sh  = c[26:22];
        imm = c[15:0];
        case (c[21:16])
            6'b100100: r = rs & rt;
            6'b100101: r = rs | rt;
            6'b100000: r = rs + rt;
            6'b100010: r = rs - rt;
            6'b000000: r = rt << sh;
            default:   r = rs ^ {16'h0, imm};
        endcase
        return {rs == rt, r};
    endfunction

    assign {alu_sig_branch, alu_result} = aluFunc({alu_opcode, alu_rs_content, alu_rt_content,
                                                    alu_shamt, alu_ALU_control, alu_immediate});

    function automatic logic [96:0] randCmd();
        logic [5:0]  ctl;
        logic [31:0] rs, rt;
        case ($urandom_range(0, 5))
            0: ctl = 6'b100100;
            1: ctl = 6'b100101;
            2: ctl = 6'b100000;
            3: ctl = 6'b100010;
            4: ctl = 6'b000000;
            default: ctl = 6'b001000;
        endcase
        rs = $urandom;
        rt = ($urandom_range(0, 3) == 0) ? rs : 32'($urandom);
        return makeCmd(6'($urandom), rs, rt, 5'($urandom), ctl, 16'($urandom));
    endfunction

    function automatic int predictWinner(input logic v0, input logic v1, input int last);
`ifdef ALU_ARB_FIXED_PRIO_EN
        return (v0 || last < 0) ? 0 : 1;
`else
        if (v0 && v1) return (last == 0) ? 1 : 0;
        return v0 ? 0 : 1;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [96:0] observed, input logic [96:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic v1, input logic [96:0] c0, input logic [96:0] c1);
        req0_valid = v0;
        req1_valid = v1;
        req0_cmd   = c0;
        req1_cmd   = c1;
    endtask

    function automatic logic [96:0] aluBus();
        return {alu_opcode, alu_rs_content, alu_rt_content, alu_shamt, alu_ALU_control, alu_immediate};
    endfunction

    task automatic checkResetState();
        checkOutput("rst_alu", aluBus(), '0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_id", rsp_id, 0);
        checkOutput("rst_rsp_result", rsp_result, 0);
        checkOutput("rst_rsp_branch", rsp_branch, 0);
        checkOutput("rst_ops_done", ops_done, 0);
        checkOutput("rst_busy", busy, 0);
    endtask

    // Called at a negedge while the DUT is idle; returns at the negedge after the response.
    task automatic runOp(input logic v0, input logic v1, input logic [96:0] c0, input logic [96:0] c1);
        int          w;
        logic [96:0] wc;
        logic [32:0] er;
        applyStimulus(v0, v1, c0, c1);
        #1;
        w  = predictWinner(v0, v1, lastWinner);
        wc = (w == 1) ? c1 : c0;
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_rsp_valid", rsp_valid, 0);
        checkOutput("idle_ops_done", ops_done, 97'(expOps));
        checkOutput("hold_rsp_result", rsp_result, expResult);
        checkOutput("hold_rsp_branch", rsp_branch, expBranch);
        checkOutput("hold_rsp_id", rsp_id, expId);
        checkOutput("grant_ready0", req0_ready, (w == 0));
        checkOutput("grant_ready1", req1_ready, (w == 1));
        lastWinner = w;
        @(negedge clk);
        checkOutput("exec_busy", busy, 1);
        checkOutput("exec_rsp_valid", rsp_valid, 0);
        checkOutput("exec_ready0", req0_ready, 0);
        checkOutput("exec_ready1", req1_ready, 0);
        checkOutput("exec_alu", aluBus(), wc);
        applyStimulus(v0, v1, randCmd(), randCmd());
        #1;
        checkOutput("exec_alu_after_change", aluBus(), wc);
        @(negedge clk);
        er        = aluFunc(wc);
        expResult = er[31:0];
        expBranch = er[32];
        expId     = (w == 1);
        checkOutput("resp_rsp_valid", rsp_valid, 1);
        checkOutput("resp_busy", busy, 1);
        checkOutput("resp_rsp_id", rsp_id, expId);
        checkOutput("resp_rsp_result", rsp_result, expResult);
        checkOutput("resp_rsp_branch", rsp_branch, expBranch);
        checkOutput("resp_alu", aluBus(), wc);
        checkOutput("resp_ready0", req0_ready, 0);
        checkOutput("resp_ready1", req1_ready, 0);
        expOps = (expOps + 1) & 16'hFFFF;
        @(negedge clk);
    endtask

    task automatic idleStep();
        applyStimulus(1'b0, 1'b0, randCmd(), randCmd());
        #1;
        checkOutput("noreq_ready0", req0_ready, 0);
        checkOutput("noreq_ready1", req1_ready, 0);
        @(negedge clk);
        checkOutput("noreq_busy", busy, 0);
        checkOutput("noreq_rsp_valid", rsp_valid, 0);
        checkOutput("noreq_ops_done", ops_done, 97'(expOps));
    endtask

    initial begin
        logic [96:0] cmdA, cmdB, cmdOr;
        logic        v0, v1;

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        checkResetState();
        rst = 1'b0;
        @(negedge clk);

        // Tie alternation straight out of reset.
        cmdA = makeCmd(6'd0, 32'b11111, 32'b11111, 5'd0, 6'b100101, 16'd0);
        cmdB = makeCmd(6'd0, 32'b1001, 32'b1011, 5'd0, 6'b100101, 16'd0);
        for (int i = 0; i < 4; i++) begin
            runOp(1'b1, 1'b1, cmdA, cmdB);
`ifdef ALU_ARB_FIXED_PRIO_EN
            checkOutput("fixed_id", rsp_id, 0);
            checkOutput("fixed_result", rsp_result, 32'b11111);
`else
            checkOutput("alt_id", rsp_id, 97'(i % 2));
            checkOutput("alt_result", rsp_result, (i % 2 == 0) ? 32'b11111 : 32'b1011);
`endif
        end
        idleStep();

        // Single requester OR example.
        cmdOr = makeCmd(6'd0, 32'b101, 32'b010, 5'd0, 6'b100101, 16'd0);
        runOp(1'b1, 1'b0, cmdOr, randCmd());
        checkOutput("or_result", rsp_result, 32'b111);
        checkOutput("or_id", rsp_id, 0);
        idleStep();
        checkOutput("or_ops_done", ops_done, 97'(5));

        for (int i = 0; i < 24; i++) begin
            v0 = 1'($urandom);
            v1 = 1'($urandom);
            if (!v0 && !v1) v1 = 1'b1;
            runOp(v0, v1, randCmd(), randCmd());
            if ($urandom_range(0, 3) == 0) idleStep();
        end

        // Reset during EXEC aborts the op.
        applyStimulus(1'b1, 1'b1, randCmd(), randCmd());
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkResetState();
        lastWinner = 1;
        expOps     = 0;
        expResult  = '0;
        expBranch  = 1'b0;
        expId      = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) idleStep();
        runOp(1'b1, 1'b1, randCmd(), randCmd());
        checkOutput("post_rst_tie_id", rsp_id, 0);

        // Counter wrap from a preset of 65535 completed operations.
        idleStep();
        force dut.r_opsDone = 16'hFFFF;
        #1;
        release dut.r_opsDone;
        expOps = 16'hFFFF;
        runOp(1'b1, 1'b0, randCmd(), randCmd());
        checkOutput("wrap_ops_done", ops_done, 0);
        idleStep();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
